// File: rtl/ln_neuron_seq.sv
// ln_neuron_seq: time-multiplexed 4-in/2-out truth-table neurons, one neuron per cycle.
// Latency: out_valid appears NEURONS cycles after the accept edge; out_data and out_valid
// then hold until out_ready. Optional macro LN_NEURON_SEQ_PERF_EN adds the perf_frames counter.
module ln_neuron_seq #(
  parameter int NEURONS = 8,
  parameter int FANIN   = 4,
  parameter int OBITS   = 2,
  // The index field can express NEURONS itself, so out-of-range writes are representable
  localparam int IW      = $clog2(NEURONS + 1),
  localparam int AW      = IW + FANIN,
  localparam int ENTRIES = 2 ** FANIN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FANIN*NEURONS-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OBITS*NEURONS-1:0]   out_data,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [OBITS-1:0]           cfg_data,
  output logic                       cfg_err
`ifdef LN_NEURON_SEQ_PERF_EN
  ,
  output logic [15:0]                perf_frames
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NEURONS - 1);

  logic [1:0]                                   state_q, state_d;
  logic [IW-1:0]                                idx_q, idx_d;
  logic [FANIN*NEURONS-1:0]                     frame_q, frame_d;
  logic [OBITS*NEURONS-1:0]                     out_data_q, out_data_d;
  logic                                         cfg_err_q, cfg_err_d;
  logic [NEURONS-1:0][ENTRIES-1:0][OBITS-1:0]   tbl_q, tbl_d;

  logic [IW-1:0]    cfg_n;
  logic [FANIN-1:0] cfg_e;
  logic             cfg_ok;

  assign cfg_n  = cfg_addr[AW-1:FANIN];
  assign cfg_e  = cfg_addr[FANIN-1:0];
  assign cfg_ok = (cfg_n <= LAST_IDX);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;

  // Next-state: frame sequencing, shared lookup, and table writes (legal only in IDLE)
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    out_data_d = out_data_q;
    tbl_d      = tbl_q;
    cfg_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          frame_d = in_data;
          idx_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        for (int n = 0; n < NEURONS; n++) begin
          if (idx_q == IW'(n)) begin
            out_data_d[n*OBITS +: OBITS] = tbl_q[n][frame_q[n*FANIN +: FANIN]];
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A write landing on the accept edge is visible to the lookup, which starts next cycle
    if (cfg_we) begin
      if (!cfg_ok || state_q != S_IDLE) begin
        cfg_err_d = 1'b1;
      end else begin
        for (int n = 0; n < NEURONS; n++) begin
          if (cfg_n == IW'(n)) begin
            tbl_d[n][cfg_e] = cfg_data;
          end
        end
      end
    end
  end

  // State registers; reset discards any frame in flight and clears all tables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
      tbl_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      out_data_q <= out_data_d;
      cfg_err_q  <= cfg_err_d;
      tbl_q      <= tbl_d;
    end
  end

`ifdef LN_NEURON_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  assign perf_frames = perf_q;

  // Saturating count of completed output handshakes
  always_comb begin
    perf_d = perf_q;
    if (out_valid && out_ready && perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Performance counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end
`endif

endmodule

// File: tb/tb_ln_neuron_seq.sv
// Self-checking bench for ln_neuron_seq (NEURONS=8) against a table-lookup reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ln_neuron_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_err;
`ifdef LN_NEURON_SEQ_PERF_EN
  logic [15:0] perf_frames;
  int          hs_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference truth tables: mtbl[neuron][entry]
  logic [1:0] mtbl [8][16];

  always #5 clk = ~clk;

  ln_neuron_seq #(.NEURONS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err)
`ifdef LN_NEURON_SEQ_PERF_EN
    ,
    .perf_frames(perf_frames)
`endif
  );

`ifdef LN_NEURON_SEQ_PERF_EN
  // Independent count of output handshakes for the perf counter
  always @(posedge clk or posedge rst) begin
    if (rst) hs_cnt <= 0;
    else if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] d);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[2*k +: 2] = mtbl[k][d[4*k +: 4]];
    return r;
  endfunction

  function automatic void clear_model();
    for (int n = 0; n < 8; n++)
      for (int e = 0; e < 16; e++) mtbl[n][e] = 2'b00;
  endfunction

  // Called right after a falling edge while idle; returns one falling edge after the write edge
  task automatic cfg_write(input int n, input int e, input logic [1:0] d, input logic exp_err);
    logic [3:0] nn;
    logic [3:0] ee;
    nn = 4'(n);
    ee = 4'(e);
    cfg_we = 1'b1; cfg_addr = {nn, ee}; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err_pulse", cfg_err, exp_err);
    if (!exp_err) mtbl[n][e] = d;
    if (exp_err) begin
      @(negedge clk);
      chk("cfg_err_single", cfg_err, 1'b0);
    end
  endtask

  // Present a frame for exactly one accept cycle; returns in cycle 1 (accept cycle is 0)
  task automatic send(input logic [31:0] d);
    chk("send_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency (cycle 9 counting accept as 0), hold, then handshake
  task automatic collect(input logic [15:0] exp, input int c0, input int hold, output logic [15:0] got);
    int c;
    c = c0;
    while (!out_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("latency", c, 9);
    got = out_data;
    chk("out_data", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_vld", out_valid, 1'b1);
      chk("hold_dat", out_data, got);
      chk("hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("vld_drop", out_valid, 1'b0);
    chk("rdy_back", in_ready, 1'b1);
    chk("dat_stable_idle", out_data, got);
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] got;
    logic [1:0]  nv;
    logic [31:0] q[$];
    int          last, acc, seen_vld;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    chk("rdy_after_rst", in_ready, 1'b1);

    // Neuron 0 example table, nibble0 = 0100 selects 11
    cfg_write(0, 4'b0000, 2'b01, 1'b0);
    cfg_write(0, 4'b1000, 2'b00, 1'b0);
    cfg_write(0, 4'b0100, 2'b11, 1'b0);
    cfg_write(0, 4'b0001, 2'b11, 1'b0);
    cfg_write(0, 4'b0111, 2'b11, 1'b0);
    d = $urandom;
    d[3:0] = 4'b0100;
    send(d);
    collect(model(d), 1, 5, got);
    chk("n0_entry_0100", {30'd0, got[1:0]}, 32'd3);

    // Random tables, random frames, random backpressure
    for (int n = 0; n < 8; n++)
      for (int e = 0; e < 16; e++) cfg_write(n, e, 2'($urandom), 1'b0);
    for (int f = 0; f < 6; f++) begin
      d = $urandom;
      send(d);
      collect(model(d), 1, $urandom_range(0, 3), got);
    end

    // Write during EVAL is rejected with one err pulse; the table is untouched
    d = $urandom;
    send(d);
    cfg_we = 1'b1; cfg_addr = {4'd1, d[7:4]}; cfg_data = ~mtbl[1][d[7:4]];
    @(negedge clk);
    cfg_we = 1'b0;
    chk("eval_wr_err", cfg_err, 1'b1);
    @(negedge clk);
    chk("eval_wr_err_once", cfg_err, 1'b0);
    collect(model(d), 3, 0, got);
    send(d);
    collect(model(d), 1, 0, got);

    // Out-of-range neuron index 9 is rejected in IDLE
    cfg_write(9, 3, 2'b11, 1'b1);

    // Write and accept in the same IDLE cycle: lookup sees the new value
    d = $urandom;
    nv = ~mtbl[2][d[11:8]];
    chk("same_cyc_rdy", in_ready, 1'b1);
    cfg_we = 1'b1; cfg_addr = {4'd2, d[11:8]}; cfg_data = nv;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("same_cyc_no_err", cfg_err, 1'b0);
    mtbl[2][d[11:8]] = nv;
    collect(model(d), 1, 0, got);
    chk("same_cyc_slice", {30'd0, got[5:4]}, {30'd0, nv});

    // Reset while evaluating neuron 3 discards the frame and clears the tables
    d = $urandom;
    send(d);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_dat", out_data, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    chk("mid_rst_rdy", in_ready, 1'b1);
    seen_vld = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen_vld++;
    end
    chk("no_vld_after_rst", seen_vld, 0);
    d = $urandom;
    send(d);
    collect(16'h0, 1, 0, got);

    // Back-to-back frames with reload of random tables
    for (int n = 0; n < 8; n++)
      for (int e = 0; e < 16; e++) cfg_write(n, e, 2'($urandom), 1'b0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = $urandom;
    last = -1; acc = 0;
    for (int cyc = 0; cyc < 62; cyc++) begin
      if (out_valid) begin
        if (q.size() > 0) chk("b2b_data", out_data, model(q.pop_front()));
        else chk("b2b_spurious_vld", out_valid, 1'b0);
      end
      if (in_ready) begin
        q.push_back(in_data);
        if (last >= 0) chk("b2b_gap", cyc - last, 10);
        last = cyc;
        acc++;
      end
      @(negedge clk);
      if (!in_ready) in_data = $urandom;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid && q.size() > 0) chk("b2b_drain_data", out_data, model(q.pop_front()));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b2b_accepts", acc, 7);
    chk("b2b_all_out", q.size(), 0);
`ifdef LN_NEURON_SEQ_PERF_EN
    chk("perf_frames", perf_frames, hs_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
